// File: rtl/alu_hs.sv
// alu_hs: registered ALU with a valid/ready handshake on both sides.
//
// One operation is in flight at a time. Single-cycle operations (add, sub,
// logic, shifts, compares, illegal opcodes) load Result on the accept edge.
// MUL runs an unsigned shift-add multiplier with one partial product per
// cycle. The result holds until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operation presented
//   in_ready   block accepts an operation this cycle
//   A, B       operands (WIDTH bits)
//   ALUSel     4-bit opcode
//   out_valid  Result and flags valid
//   out_ready  consumer takes Result this cycle
//   Result     registered result (WIDTH bits)
//   ZFlag      Result == 0
//   NFlag      Result sign bit
//   CFlag      carry / borrow / multiply overflow
//   VFlag      signed overflow
module alu_hs #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUSel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             ZFlag,
  output logic             NFlag,
  output logic             CFlag,
  output logic             VFlag
);

  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_q, c_d;
  logic               v_q, v_d;
  // Flags read 0 from reset until the first result has been produced.
  logic               flags_en_q, flags_en_d;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept;
  logic [SHW-1:0]     sh_amt;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [2*WIDTH-1:0] prod_sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  assign sh_amt   = B[SHW-1:0];
  assign add_full = {1'b0, A} + {1'b0, B};
  // The top bit of the extended difference is the unsigned borrow.
  assign sub_full = {1'b0, A} - {1'b0, B};
  // Accumulator plus the current partial product; also the final product
  // on the last iteration, so Result loads without an extra cycle.
  assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle datapath. MUL and illegal opcodes fall to the zero default.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUSel)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (A[MSB] == B[MSB]) && (add_full[MSB] != A[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (A[MSB] != B[MSB]) && (sub_full[MSB] != A[MSB]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NOR:  alu_res = ~(A | B);
      OP_XOR:  alu_res = A ^ B;
      OP_SLL:  alu_res = A << sh_amt;
      OP_SRL:  alu_res = A >> sh_amt;
      OP_SRA:  alu_res = WIDTH'($signed(A) >>> sh_amt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: alu_res = '0;
    endcase
  end

  // Next-state logic and handshake.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    c_d        = c_q;
    v_d        = v_q;
    flags_en_d = flags_en_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;

    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_BUSY: begin
        prod_d   = prod_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_HOLD;
          result_d   = prod_sum[WIDTH-1:0];
          c_d        = |prod_sum[2*WIDTH-1:WIDTH];
          v_d        = 1'b0;
          flags_en_d = 1'b1;
        end
      end
      ST_HOLD: begin
        // A new operation can only enter as the held result leaves.
        in_ready = out_ready;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    accept = in_valid && in_ready;

    if (accept) begin
      if (ALUSel == OP_MUL) begin
        state_d  = ST_BUSY;
        mcand_d  = {{WIDTH{1'b0}}, A};
        mplier_d = B;
        prod_d   = '0;
        cnt_d    = '0;
      end else begin
        state_d    = ST_HOLD;
        result_d   = alu_res;
        c_d        = alu_c;
        v_d        = alu_v;
        flags_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      flags_en_q <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      c_q        <= c_d;
      v_q        <= v_d;
      flags_en_q <= flags_en_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign Result    = result_q;
  assign ZFlag     = flags_en_q && (result_q == '0);
  assign NFlag     = result_q[MSB];
  assign CFlag     = c_q;
  assign VFlag     = v_q;

endmodule

// File: tb/tb_alu_hs.sv
// tb_alu_hs: self-checking bench for alu_hs (WIDTH=8).
// Directed cases plus randomized operations checked against a behavioural
// model built from integer arithmetic.
module tb_alu_hs;

  localparam int W      = 8;
  localparam int MAXS   = (1 << (W - 1)) - 1;
  localparam int MINS   = -(1 << (W - 1));
  localparam int OP_MUL = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALUSel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         ZFlag;
  logic         NFlag;
  logic         CFlag;
  logic         VFlag;

  int checks = 0;
  int passes = 0;

  alu_hs #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUSel    (ALUSel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .ZFlag     (ZFlag),
    .NFlag     (NFlag),
    .CFlag     (CFlag),
    .VFlag     (VFlag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: what each opcode means, in integer arithmetic.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] op, output logic [W-1:0] res,
                                    output logic c, output logic v);
    int ua, ub, sa, sb, t, sh;
    longint p;
    logic signed [W-1:0] a_s, b_s;
    ua = a; ub = b; a_s = a; b_s = b; sa = a_s; sb = b_s;
    sh = ub % W;
    res = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        t = ua + ub; res = W'(t); c = (t >= (1 << W));
        t = sa + sb; v = (t > MAXS) || (t < MINS);
      end
      4'd1: begin
        t = ua - ub; res = W'(t); c = (ua < ub);
        t = sa - sb; v = (t > MAXS) || (t < MINS);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = ~(a | b);
      4'd5: res = a ^ b;
      4'd6: begin t = ua << sh; res = W'(t); end
      4'd7: begin t = ua >> sh; res = W'(t); end
      4'd8: begin t = sa >>> sh; res = W'(t); end
      4'd9: begin
        p = longint'(ua) * longint'(ub);
        res = W'(p); c = ((p >> W) != 0);
      end
      4'd10: res = (sa < sb) ? W'(1) : W'(0);
      4'd11: res = (ua < ub) ? W'(1) : W'(0);
      default: res = '0;
    endcase
  endfunction

  // Wait for out_valid; lat counts edges from the accept edge to the edge at
  // which the consumer first sees out_valid.
  task automatic await_valid(input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < W + 4) begin
      check("busy_in_ready", in_ready, 0);
      step();
      lat++;
    end
    check("latency", lat, exp_lat);
  endtask

  // One isolated operation from IDLE: accept, wait, compare, hold, drain.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input int hold);
    int guard;
    logic [W-1:0] er;
    logic ec, ev;
    ref_model(a, b, op, er, ec, ev);
    out_ready = 1'b0;
    A = a; B = b; ALUSel = op; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin step(); guard++; end
    check("accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); ALUSel = 4'($urandom);
    await_valid((op == OP_MUL) ? W + 1 : 1);
    check("result", Result, er);
    check("flags", {ZFlag, NFlag, CFlag, VFlag}, {(er == '0), er[W-1], ec, ev});
    $display("op=%0d A=%02h B=%02h -> Result=%02h ZNCV=%b%b%b%b (model %02h)",
             op, a, b, Result, ZFlag, NFlag, CFlag, VFlag, er);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_result", Result, er);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
  endtask

  // Back-to-back single-cycle ops with out_ready held high.
  task automatic burst(input int n);
    logic [W-1:0] a, b, er;
    logic [3:0] op;
    logic ec, ev;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = W'($urandom); b = W'($urandom); op = 4'($urandom_range(0, 15));
      if (op == 4'd9) op = 4'd0;
      A = a; B = b; ALUSel = op; in_valid = 1'b1;
      check("b2b_ready", in_ready, 1);
      step();
      ref_model(a, b, op, er, ec, ev);
      check("b2b_valid", out_valid, 1);
      check("b2b_result", Result, er);
      check("b2b_flags", {ZFlag, NFlag, CFlag, VFlag}, {(er == '0), er[W-1], ec, ev});
      $display("b2b op=%0d A=%02h B=%02h -> Result=%02h (model %02h)", op, a, b, Result, er);
    end
    in_valid = 1'b0;
    step();
    check("b2b_drain", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0] rop;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUSel = '0;
    step(); step();
    rst = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", Result, 0);
    check("rst_flags", {ZFlag, NFlag, CFlag, VFlag}, 4'b0000);

    run_op(8'hFF, 8'h01, 4'd0, 0);
    check("tp_add_res", Result, 8'h00);
    check("tp_add_flags", {ZFlag, NFlag, CFlag, VFlag}, 4'b1010);
    run_op(8'h80, 8'h01, 4'd1, 1);
    check("tp_sub1_res", Result, 8'h7F);
    check("tp_sub1_flags", {ZFlag, NFlag, CFlag, VFlag}, 4'b0001);
    run_op(8'h01, 8'h02, 4'd1, 0);
    check("tp_sub2_res", Result, 8'hFF);
    check("tp_sub2_flags", {ZFlag, NFlag, CFlag, VFlag}, 4'b0110);
    run_op(8'h10, 8'h11, 4'd9, 2);
    check("tp_mul1_res", Result, 8'h10);
    check("tp_mul1_c", CFlag, 1);
    run_op(8'h0F, 8'h03, 4'd9, 0);
    check("tp_mul2_res", Result, 8'h2D);
    check("tp_mul2_c", CFlag, 0);

    // Backpressure, then a new op accepted as the old result leaves.
    out_ready = 1'b0;
    A = 8'h03; B = 8'h04; ALUSel = 4'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_result", Result, 8'h07);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_result", Result, 8'h07);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    A = 8'hF0; B = 8'h0F; ALUSel = 4'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_xor_result", Result, 8'hFF);
    check("bp_xor_valid", out_valid, 1);
    $display("backpressure: ADD 3+4 held, then XOR -> Result=%02h", Result);
    step();
    out_ready = 1'b0;
    check("bp_drain", out_valid, 0);

    run_op(8'h90, 8'h02, 4'd8, 0);
    check("tp_sra", Result, 8'hE4);
    run_op(8'h90, 8'h02, 4'd7, 0);
    check("tp_srl", Result, 8'h24);
    run_op(8'hFF, 8'h01, 4'd10, 0);
    check("tp_slt", Result, 8'h01);
    run_op(8'hFF, 8'h01, 4'd11, 0);
    check("tp_sltu", Result, 8'h00);
    run_op(8'h5A, 8'h33, 4'b1110, 0);
    check("tp_illegal_res", Result, 8'h00);
    check("tp_illegal_flags", {ZFlag, NFlag, CFlag, VFlag}, 4'b1000);

    // HOLD with out_ready and a MUL accept: out_valid drops while busy.
    out_ready = 1'b1;
    A = 8'h02; B = 8'h02; ALUSel = 4'd0; in_valid = 1'b1;
    step();
    check("hm_add_res", Result, 8'h04);
    A = 8'h0F; B = 8'h03; ALUSel = 4'd9;
    step();
    in_valid = 1'b0;
    check("hm_valid_drop", out_valid, 0);
    await_valid(W + 1);
    check("hm_mul_res", Result, 8'h2D);
    $display("hold->mul: Result=%02h", Result);
    step();
    out_ready = 1'b0;
    check("hm_drain", out_valid, 0);

    burst(20);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 8'h80;
        1: ra = 8'h7F;
        default: ra = W'($urandom);
      endcase
      rb = W'($urandom);
      rop = 4'($urandom_range(0, 15));
      run_op(ra, rb, rop, $urandom_range(0, 3));
    end

    // Reset during the fourth cycle of a MUL discards it.
    out_ready = 1'b1;
    A = 8'h10; B = 8'h11; ALUSel = 4'd9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_valid", out_valid, 0);
    check("mr_result", Result, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_flags", {ZFlag, NFlag, CFlag, VFlag}, 4'b0000);
    repeat (W + 2) step();
    check("mr_no_late_valid", out_valid, 0);
    $display("reset mid-MUL: out_valid=%0b Result=%02h", out_valid, Result);
    run_op(8'h01, 8'h01, 4'd0, 0);
    check("mr_add_res", Result, 8'h02);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
